multicycle_control_unit: RTL and testbench

- Moore FSM that sequences the multicycle RV32I datapath.
- Drives the PC enable, address mux, memory write, IR/OldPC enable, register-file write, SrcA/SrcB mux selects, immediate select, ALU control and result-select mux.
- Consumes the opcode/funct fields of the instruction register, the ALU zero flag and a memory-ready handshake.

---
 rtl/multicycle_control_unit_pkg.sv | 78 +++++++
 rtl/multicycle_control_unit_if.sv | 59 +++++
 rtl/multicycle_control_unit_alu_decoder.sv | 37 +++
 rtl/multicycle_control_unit.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_ctrl_pkg: state, opcode, ALU, immediate and mux encodings shared
// by the multicycle RV32I control unit, its ALU decoder and its interface.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        EXEC_LUI  = 4'd9,
        ALU_WB    = 4'd10,
        BRANCH    = 4'd11,
        JAL       = 4'd12,
        JALR_ADDR = 4'd13,
        JALR      = 4'd14,
        ILLEGAL   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_ctrl_t;

    // Operation class chosen by the FSM; ALUOP_FUNCT defers to funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_PASSB = 2'd3
    } aluop_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;

    localparam logic [1:0] SRCA_PC       = 2'd0;
    localparam logic [1:0] SRCA_OLDPC    = 2'd1;
    localparam logic [1:0] SRCA_RS1      = 2'd2;

    localparam logic [1:0] SRCB_RS2      = 2'd0;
    localparam logic [1:0] SRCB_IMM      = 2'd1;
    localparam logic [1:0] SRCB_FOUR     = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields, status and control strobes
// between the control unit (master) and the datapath (slave).
// Build option MCU_INSTRET_EN adds the retired-instruction count.
interface multicycle_control_unit_if #(
    parameter int STATE_W = 4
`ifdef MCU_INSTRET_EN
    , parameter int INSTRET_W = 32
`endif
);
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7_b5;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         imm_sel;
    logic [3:0]         alu_control;
    logic [1:0]         result_src;
    logic               illegal_instr;
    logic [STATE_W-1:0] state_o;
`ifdef MCU_INSTRET_EN
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7_b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_control, result_src,
               illegal_instr, state_o, instret
    );

    modport slave (
        output opcode, funct3, funct7_b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_control, result_src,
               illegal_instr, state_o, instret
    );
`else
    modport master (
        input  opcode, funct3, funct7_b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_control, result_src,
               illegal_instr, state_o
    );

    modport slave (
        output opcode, funct3, funct7_b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_control, result_src,
               illegal_instr, state_o
    );
`endif
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: combinational mapping from the FSM's ALU operation class and
// the instruction funct fields to the ALU control code.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  aluop_t     aluOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       isRtype,
    output alu_ctrl_t  aluControl
);

    // Pick the ALU operation; funct7[5] only selects SUB for R-type, SRA for any shift-right.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD:   aluControl = ALU_ADD;
            ALUOP_SUB:   aluControl = ALU_SUB;
            ALUOP_PASSB: aluControl = ALU_PASS_B;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: aluControl = (isRtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: aluControl = ALU_SLL;
                    3'b010: aluControl = ALU_SLT;
                    3'b011: aluControl = ALU_SLTU;
                    3'b100: aluControl = ALU_XOR;
                    3'b101: aluControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: aluControl = ALU_OR;
                    3'b111: aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle RV32I datapath.
// Outputs depend on the state register only, except fetch/store enables that
// are qualified by mem_ready and the branch PC enable qualified by zero.
// Build option MCU_INSTRET_EN adds a retired-instruction counter (bus.instret).
module multicycle_control_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
`ifdef MCU_INSTRET_EN
    , parameter int INSTRET_W = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    state_t    state;
    state_t    nextState;

    logic      pcWrite;
    logic      adrSrc;
    logic      memWrite;
    logic      irWrite;
    logic      regWrite;
    logic [1:0] srcA;
    logic [1:0] srcB;
    imm_sel_t  immSel;
    aluop_t    aluOp;
    logic [1:0] resultSrc;
    logic      illegal;
    logic      isRtype;
    alu_ctrl_t aluControl;

    // State register; reset drops straight to IDLE so no write survives the reset edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state sequencing.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      nextState = FETCH;
            FETCH:     if (bus.mem_ready) nextState = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: nextState = MEM_ADDR;
                    OP_RTYPE:          nextState = EXEC_R;
                    OP_ITYPE:          nextState = EXEC_I;
                    OP_BRANCH:         nextState = BRANCH;
                    OP_JAL:            nextState = JAL;
                    OP_JALR:           nextState = JALR_ADDR;
                    OP_LUI:            nextState = EXEC_LUI;
                    default:           nextState = ILLEGAL;
                endcase
            end
            MEM_ADDR:  nextState = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (bus.mem_ready) nextState = MEM_WB;
            MEM_WB:    nextState = FETCH;
            MEM_WRITE: if (bus.mem_ready) nextState = FETCH;
            EXEC_R:    nextState = ALU_WB;
            EXEC_I:    nextState = ALU_WB;
            EXEC_LUI:  nextState = ALU_WB;
            ALU_WB:    nextState = FETCH;
            BRANCH:    nextState = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) ? FETCH : ILLEGAL;
            JAL:       nextState = ALU_WB;
            JALR_ADDR: nextState = JALR;
            JALR:      nextState = ALU_WB;
            ILLEGAL:   nextState = ILLEGAL;
            default:   nextState = ILLEGAL;
        endcase
    end

    // Control outputs per state; everything defaults to 0 (idle datapath).
    always_comb begin
        pcWrite   = 1'b0;
        adrSrc    = ADR_PC;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        srcA      = SRCA_PC;
        srcB      = SRCB_RS2;
        immSel    = IMM_I;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALUOUT;
        illegal   = 1'b0;
        case (state)
            FETCH: begin
                srcB      = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                irWrite   = bus.mem_ready;
                pcWrite   = bus.mem_ready;
            end
            DECODE: begin
                srcA   = SRCA_OLDPC;
                srcB   = SRCB_IMM;
                immSel = IMM_B;
            end
            MEM_ADDR: begin
                srcA   = SRCA_RS1;
                srcB   = SRCB_IMM;
                immSel = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEM_READ:  adrSrc = ADR_ALUOUT;
            MEM_WB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
            end
            MEM_WRITE: begin
                adrSrc   = ADR_ALUOUT;
                memWrite = bus.mem_ready;
            end
            EXEC_R: begin
                srcA  = SRCA_RS1;
                aluOp = ALUOP_FUNCT;
            end
            EXEC_I: begin
                srcA  = SRCA_RS1;
                srcB  = SRCB_IMM;
                aluOp = ALUOP_FUNCT;
            end
            EXEC_LUI: begin
                srcB   = SRCB_IMM;
                immSel = IMM_U;
                aluOp  = ALUOP_PASSB;
            end
            ALU_WB:    regWrite = 1'b1;
            BRANCH: begin
                srcA  = SRCA_RS1;
                aluOp = ALUOP_SUB;
                case (bus.funct3)
                    3'b000:  pcWrite = bus.zero;
                    3'b001:  pcWrite = !bus.zero;
                    default: pcWrite = 1'b0;
                endcase
            end
            JAL, JALR: begin
                pcWrite = 1'b1;
                srcA    = SRCA_OLDPC;
                srcB    = SRCB_FOUR;
            end
            JALR_ADDR: begin
                srcA = SRCA_RS1;
                srcB = SRCB_IMM;
            end
            ILLEGAL:   illegal = 1'b1;
            default:   ;
        endcase
    end

    assign isRtype = (state == EXEC_R);

    alu_decoder uAluDecoder (
        .aluOp      (aluOp),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7_b5),
        .isRtype    (isRtype),
        .aluControl (aluControl)
    );

    assign bus.pc_write      = pcWrite;
    assign bus.adr_src       = adrSrc;
    assign bus.mem_write     = memWrite;
    assign bus.ir_write      = irWrite;
    assign bus.reg_write     = regWrite;
    assign bus.alu_src_a     = srcA;
    assign bus.alu_src_b     = srcB;
    assign bus.imm_sel       = immSel;
    assign bus.alu_control   = aluControl;
    assign bus.result_src    = resultSrc;
    assign bus.illegal_instr = illegal;
    assign bus.state_o       = STATE_W'(state);

`ifdef MCU_INSTRET_EN
    logic [INSTRET_W-1:0] instretCount;
    logic                 retire;

    // An instruction retires on its last cycle: entering FETCH from anything but IDLE/FETCH.
    assign retire = (nextState == FETCH) && (state != IDLE) && (state != FETCH);

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instretCount <= '0;
        end else if (retire) begin
            instretCount <= instretCount + INSTRET_W'(1);
        end
    end

    assign bus.instret = instretCount;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed vector table, randomized instruction
// stream with random memory stalls, and hand-written reset/illegal sequences.
// The reference model derives per-cycle expectations from each instruction's
// class and its stall plan. Define MCU_INSTRET_EN to also check instret.
module tb_multicycle_control_unit;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_R     = 2;
    localparam int K_I     = 3;
    localparam int K_LUI   = 4;
    localparam int K_BR    = 5;
    localparam int K_JAL   = 6;
    localparam int K_JALR  = 7;
    localparam int K_BAD   = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    multicycle_control_unit_if busIf ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int expRetired  = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         fStall;
        int         mStall;
        int         zeroVal;
        int         cycles;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // en = {pc_write, ir_write, reg_write, mem_write, adr_src, illegal_instr}
    // sel = {alu_src_a, alu_src_b, imm_sel, alu_control, result_src}
    task automatic checkCycle(input string tag, input int eEn, input int eSel, input int eState);
        check({tag, " en"}, int'({busIf.pc_write, busIf.ir_write, busIf.reg_write,
                                 busIf.mem_write, busIf.adr_src, busIf.illegal_instr}), eEn);
        check({tag, " sel"}, int'({busIf.alu_src_a, busIf.alu_src_b, busIf.imm_sel,
                                  busIf.alu_control, busIf.result_src}), eSel);
        if (eState >= 0) check({tag, " state"}, int'(busIf.state_o), eState);
    endtask

    function automatic int kindOf(input logic [6:0] op);
        case (op)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0110111: return K_LUI;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_BAD;
        endcase
    endfunction

    // RV32I ALU operation for an R-type (isR=1) or OP-IMM instruction.
    function automatic int refAlu(input int f3, input int f7, input int isR);
        case (f3)
            0: return (isR != 0 && f7 != 0) ? 1 : 0;
            1: return 5;
            2: return 8;
            3: return 9;
            4: return 4;
            5: return (f7 != 0) ? 7 : 6;
            6: return 3;
            default: return 2;
        endcase
    endfunction

    // Runs one instruction from its first FETCH cycle; fStall/mStall are the
    // mem_ready=0 cycles in fetch and in the data-memory access.
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int fStall, input int mStall, input int zeroVal,
                            input int expTotal);
        int k, base, total, d, mr, z, st;
        int pcw, irw, regw, memw, adr, srcA, srcB, imm, alu, res;
        bit isMem;
        k = kindOf(op);
        isMem = (k == K_LOAD || k == K_STORE);
        case (k)
            K_LOAD, K_JALR: base = 5;
            K_BR:           base = 3;
            K_BAD:          base = 2;
            default:        base = 4;
        endcase
        total = (expTotal >= 0) ? expTotal : base + fStall + (isMem ? mStall : 0);
        busIf.opcode    = op;
        busIf.funct3    = f3;
        busIf.funct7_b5 = f7;
`ifdef MCU_INSTRET_EN
        check("instret at fetch", int'(busIf.instret), expRetired);
`endif
        for (int c = 0; c < total; c++) begin
            d  = c - fStall;
            mr = int'($urandom_range(0, 1));
            if (c <= fStall) mr = (c == fStall) ? 1 : 0;
            else if (isMem && d >= 3 && d <= 3 + mStall) mr = (d == 3 + mStall) ? 1 : 0;
            z = (zeroVal < 0) ? int'($urandom_range(0, 1)) : zeroVal;
            busIf.mem_ready = mr[0];
            busIf.zero      = z[0];

            pcw = 0; irw = 0; regw = 0; memw = 0; adr = 0;
            srcA = 0; srcB = 0; imm = 0; alu = 0; res = 0; st = -1;
            if (c <= fStall) begin
                srcB = 2; res = 2; pcw = mr; irw = mr; st = 1;
            end else if (d == 1) begin
                srcA = 1; srcB = 1; imm = 2; st = 2;
            end else begin
                case (k)
                    K_R:   if (d == 2) begin srcA = 2; alu = refAlu(f3, f7, 1); end else regw = 1;
                    K_I:   if (d == 2) begin srcA = 2; srcB = 1; alu = refAlu(f3, f7, 0); end else regw = 1;
                    K_LUI: if (d == 2) begin srcB = 1; imm = 3; alu = 10; end else regw = 1;
                    K_JAL: if (d == 2) begin pcw = 1; srcA = 1; srcB = 2; end else regw = 1;
                    K_JALR: begin
                        if (d == 2) begin srcA = 2; srcB = 1; end
                        else if (d == 3) begin pcw = 1; srcA = 1; srcB = 2; end
                        else regw = 1;
                    end
                    K_BR: begin
                        srcA = 2; alu = 1;
                        pcw = (f3 == 0) ? z : (f3 == 1) ? 1 - z : 0;
                    end
                    K_LOAD: begin
                        if (d == 2) begin srcA = 2; srcB = 1; end
                        else if (d <= 3 + mStall) adr = 1;
                        else begin res = 1; regw = 1; end
                    end
                    K_STORE: begin
                        if (d == 2) begin srcA = 2; srcB = 1; imm = 1; end
                        else begin adr = 1; memw = mr; end
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
            checkCycle($sformatf("op=%b f3=%0d cyc%0d", op, f3, c),
                       (pcw << 5) | (irw << 4) | (regw << 3) | (memw << 2) | (adr << 1),
                       (srcA << 11) | (srcB << 9) | (imm << 6) | (alu << 2) | res, st);
            @(posedge clk); #1;
        end
        if (k != K_BAD && !(k == K_BR && f3 > 1)) expRetired++;
    endtask

    task automatic checkIllegal(input int n);
        for (int i = 0; i < n; i++) begin
            busIf.mem_ready = 1'($urandom_range(0, 1));
            busIf.zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkCycle($sformatf("illegal cyc%0d", i), 1, 0, 15);
            @(posedge clk); #1;
        end
`ifdef MCU_INSTRET_EN
        check("instret frozen in illegal", int'(busIf.instret), expRetired);
`endif
    endtask

    // Asserts reset (checked immediately, before any clock edge), holds it, releases.
    task automatic doReset(input int n);
        rstN = 1'b0;
        #1;
        checkCycle("reset async", 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkCycle($sformatf("reset held %0d", i), 0, 0, 0);
        end
`ifdef MCU_INSTRET_EN
        check("instret reset", int'(busIf.instret), 0);
`endif
        rstN = 1'b1;
        expRetired = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        busIf.opcode    = '0;
        busIf.funct3    = '0;
        busIf.funct7_b5 = 1'b0;
        busIf.zero      = 1'b0;
        busIf.mem_ready = 1'b1;

        //          op          f3      f7    fSt mSt zero cyc
        vecs[0]  = '{7'b0110011, 3'b000, 1'b1, 0, 0, 0, 4};  // SUB
        vecs[1]  = '{7'b0110011, 3'b010, 1'b0, 0, 0, 0, 4};  // SLT
        vecs[2]  = '{7'b0010011, 3'b000, 1'b1, 0, 0, 0, 4};  // ADDI, f7 ignored
        vecs[3]  = '{7'b0010011, 3'b101, 1'b1, 0, 0, 0, 4};  // SRAI
        vecs[4]  = '{7'b0110111, 3'b000, 1'b0, 0, 0, 0, 4};  // LUI
        vecs[5]  = '{7'b1101111, 3'b000, 1'b0, 0, 0, 0, 4};  // JAL
        vecs[6]  = '{7'b1100111, 3'b000, 1'b0, 0, 0, 0, 5};  // JALR
        vecs[7]  = '{7'b0000011, 3'b010, 1'b0, 0, 2, 0, 7};  // LW, 2 stalls
        vecs[8]  = '{7'b0100011, 3'b010, 1'b0, 1, 0, 0, 5};  // SW, 1 fetch stall
        vecs[9]  = '{7'b1100011, 3'b000, 1'b0, 0, 0, 1, 3};  // BEQ taken
        vecs[10] = '{7'b1100011, 3'b000, 1'b0, 0, 0, 0, 3};  // BEQ not taken
        vecs[11] = '{7'b1100011, 3'b001, 1'b0, 0, 0, 0, 3};  // BNE taken
        vecs[12] = '{7'b0000011, 3'b010, 1'b0, 0, 0, 0, 5};  // LW no stall

        doReset(3);

        for (int i = 0; i < 13; i++)
            runInstr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].fStall,
                     vecs[i].mStall, vecs[i].zeroVal, vecs[i].cycles);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7;
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin op = 7'b0000011; f3 = 3'b010; end
                1: begin op = 7'b0100011; f3 = 3'b010; end
                2: begin op = 7'b0110011; if (f3 != 3'b000 && f3 != 3'b101) f7 = 1'b0; end
                3: op = 7'b0010011;
                4: op = 7'b0110111;
                5: begin op = 7'b1100011; f3 = {2'b00, f3[0]}; end
                6: op = 7'b1101111;
                default: begin op = 7'b1100111; f3 = 3'b000; end
            endcase
            runInstr(op, f3, f7, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, -1);
        end

        // Unknown opcode: DECODE then ILLEGAL until reset.
        runInstr(7'b1111111, 3'b000, 1'b0, 0, 0, 0, -1);
        checkIllegal(10);
        doReset(2);

        // Branch with unsupported funct3 traps without a PC write.
        runInstr(7'b1100011, 3'b100, 1'b0, 0, 0, 1, -1);
        checkIllegal(3);
        doReset(1);

        // ADDI, SW, JALR from a clean reset.
        runInstr(7'b0010011, 3'b000, 1'b0, 0, 0, 0, 4);
        runInstr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 4);
        runInstr(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 5);
`ifdef MCU_INSTRET_EN
        check("instret after 3 instr", int'(busIf.instret), 3);
`endif

        // Load aborted by reset while stalled in MEM_READ.
        busIf.opcode    = 7'b0000011;
        busIf.funct3    = 3'b010;
        busIf.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        busIf.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkCycle("load stalled", 2, 0, 4);
        @(posedge clk); #1;
        doReset(2);

        // Recovery: a plain ADD runs normally afterwards.
        runInstr(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 4);
        busIf.mem_ready = 1'b0;
        @(negedge clk);
        check("final state fetch", int'(busIf.state_o), 1);
`ifdef MCU_INSTRET_EN
        check("instret after recovery", int'(busIf.instret), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
